// File: rtl/wb_pkg.sv
// Shared types and default widths for the writeback arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_pkg;

  localparam int WB_XLEN   = 32;
  localparam int WB_ADDR_W = 5;

  // Which producer owned the last registered writeback slot.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LSU  = 2'd2,
    SRC_MD   = 2'd3
  } src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write bit vector: one bit per register with an outstanding long-latency write.
// Latency: set/clear visible one cycle after the edge that samples them.
// Backpressure: none; set takes priority over clear on the same bit.
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_en,
  input  logic [ADDR_W-1:0]      set_rd,
  input  logic                   clr_en,
  input  logic [ADDR_W-1:0]      clr_rd,
  output logic [2**ADDR_W-1:0]   pending
);

  // Clear first so a same-edge set of the same register wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (clr_en) pending[clr_rd] <= 1'b0;
      if (set_en) pending[set_rd] <= 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU fixed-high priority, LSU/MD round-robin, registered write port; scoreboard under WB_SCOREBOARD_EN.
// Latency: one cycle from grant/transfer to reg_write_o.
// Backpressure: LSU/MD ready only when no stall and no ALU result; stall freezes the output stage.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN   = WB_XLEN,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  alu_valid_i,
  input  logic [ADDR_W-1:0]     alu_rd_i,
  input  logic [XLEN-1:0]       alu_data_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [ADDR_W-1:0]     lsu_rd_i,
  input  logic [XLEN-1:0]       lsu_data_i,
  input  logic                  md_valid_i,
  output logic                  md_ready_o,
  input  logic [ADDR_W-1:0]     md_rd_i,
  input  logic [XLEN-1:0]       md_data_i,
  input  logic                  issue_valid_i,
  input  logic [ADDR_W-1:0]     issue_rd_i,
  output logic                  reg_write_o,
  output logic [ADDR_W-1:0]     write_addr_o,
  output logic [XLEN-1:0]       data_o,
  output logic [2**ADDR_W-1:0]  pending_o,
  output src_e                  last_src_o    // debug: owner of the registered slot
);

  logic            rr_q;       // 0: LSU preferred, 1: MD preferred
  logic            alu_grant;
  logic            lsu_xfer;
  logic            md_xfer;
  src_e            sel_src;
  logic [ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0] sel_data;

  // Readies are forced low in reset so no transfer can be lost to a clearing edge.
  assign lsu_ready_o = !rst_i && !stall_i && !alu_valid_i && lsu_valid_i && (!md_valid_i || !rr_q);
  assign md_ready_o  = !rst_i && !stall_i && !alu_valid_i && md_valid_i  && (!lsu_valid_i || rr_q);

  assign alu_grant = !stall_i && alu_valid_i;
  assign lsu_xfer  = lsu_valid_i && lsu_ready_o;
  assign md_xfer   = md_valid_i && md_ready_o;

  // Select the payload of whichever source is granted this cycle.
  always_comb begin
    sel_src  = SRC_NONE;
    sel_rd   = '0;
    sel_data = '0;
    if (alu_grant) begin
      sel_src  = SRC_ALU;
      sel_rd   = alu_rd_i;
      sel_data = alu_data_i;
    end else if (lsu_xfer) begin
      sel_src  = SRC_LSU;
      sel_rd   = lsu_rd_i;
      sel_data = lsu_data_i;
    end else if (md_xfer) begin
      sel_src  = SRC_MD;
      sel_rd   = md_rd_i;
      sel_data = md_data_i;
    end
  end

  // Round-robin pointer flips toward the source that did not just win.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= 1'b0;
    end else if (lsu_xfer) begin
      rr_q <= 1'b1;
    end else if (md_xfer) begin
      rr_q <= 1'b0;
    end
  end

  // Output stage: load on grant, drop the enable when idle, hold everything under stall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      reg_write_o  <= 1'b0;
      write_addr_o <= '0;
      data_o       <= '0;
      last_src_o   <= SRC_NONE;
    end else if (!stall_i) begin
      last_src_o <= sel_src;
      if (sel_src != SRC_NONE) begin
        // x0 writes are consumed but never forwarded to the register file.
        reg_write_o  <= (sel_rd != '0);
        write_addr_o <= sel_rd;
        data_o       <= sel_data;
      end else begin
        reg_write_o <= 1'b0;
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  wb_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk     (clk_i),
    .rst     (rst_i),
    .set_en  (issue_valid_i && !stall_i && (issue_rd_i != '0)),
    .set_rd  (issue_rd_i),
    .clr_en  (lsu_xfer || md_xfer),
    .clr_rd  (lsu_xfer ? lsu_rd_i : md_rd_i),
    .pending (pending_o)
  );
`else
  logic unused_issue;
  assign unused_issue = ^{issue_valid_i, issue_rd_i};
  assign pending_o    = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vectors plus a per-cycle reference model.
// Latency: model expects outputs one edge after the winning input is sampled.
// Backpressure: model predicts readies as "this source would win right now".
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 5;
`ifdef WB_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic              clk, rst, stall;
  logic              alu_valid, lsu_valid, md_valid, issue_valid;
  logic [ADDR_W-1:0] alu_rd, lsu_rd, md_rd, issue_rd;
  logic [XLEN-1:0]   alu_data, lsu_data, md_data;
  logic              lsu_ready, md_ready, reg_write;
  logic [ADDR_W-1:0] write_addr;
  logic [XLEN-1:0]   data;
  logic [31:0]       pending;
  src_e              last_src;

  int n_chk = 0;
  int n_err = 0;

  wb_arbiter #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall),
    .alu_valid_i(alu_valid), .alu_rd_i(alu_rd), .alu_data_i(alu_data),
    .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_rd_i(lsu_rd), .lsu_data_i(lsu_data),
    .md_valid_i(md_valid), .md_ready_o(md_ready), .md_rd_i(md_rd), .md_data_i(md_data),
    .issue_valid_i(issue_valid), .issue_rd_i(issue_rd),
    .reg_write_o(reg_write), .write_addr_o(write_addr), .data_o(data),
    .pending_o(pending), .last_src_o(last_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Winner codes: 0 none, 1 ALU, 2 LSU, 3 MD.
  function automatic int pick(logic a, logic l, logic m, logic prefer_md);
    if (a) return 1;
    if (l && m) return prefer_md ? 3 : 2;
    if (l) return 2;
    if (m) return 3;
    return 0;
  endfunction

  logic              pref_md;
  logic              exp_rw;
  logic [ADDR_W-1:0] exp_addr;
  logic [XLEN-1:0]   exp_data;
  logic [1:0]        exp_src;
  logic [31:0]       exp_pend;
  int                cur_win;

  always_comb begin
    cur_win = 0;
    if (!rst && !stall) cur_win = pick(alu_valid, lsu_valid, md_valid, pref_md);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_rw <= 1'b0; exp_addr <= '0; exp_data <= '0; exp_src <= 2'd0;
      exp_pend <= '0; pref_md <= 1'b0;
    end else if (!stall) begin
      case (cur_win)
        1: begin
          exp_rw <= (alu_rd != 0); exp_addr <= alu_rd; exp_data <= alu_data; exp_src <= 2'd1;
        end
        2: begin
          exp_rw <= (lsu_rd != 0); exp_addr <= lsu_rd; exp_data <= lsu_data; exp_src <= 2'd2;
          pref_md <= 1'b1;
          if (SB) exp_pend[lsu_rd] <= 1'b0;
        end
        3: begin
          exp_rw <= (md_rd != 0); exp_addr <= md_rd; exp_data <= md_data; exp_src <= 2'd3;
          pref_md <= 1'b0;
          if (SB) exp_pend[md_rd] <= 1'b0;
        end
        default: begin
          exp_rw <= 1'b0; exp_src <= 2'd0;
        end
      endcase
      if (SB && issue_valid && issue_rd != 0) exp_pend[issue_rd] <= 1'b1;
    end
  end

  // Single compare process: mid-cycle, inputs settled, outputs stable.
  always @(negedge clk) begin
    #2;
    chk("reg_write", reg_write, exp_rw);
    chk("write_addr", write_addr, exp_addr);
    chk("data", data, exp_data);
    chk("pending", pending, exp_pend);
    chk("last_src", last_src, exp_src);
    chk("lsu_ready", lsu_ready, cur_win == 2);
    chk("md_ready", md_ready, cur_win == 3);
  end

  initial begin
    #60000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; stall = 1'b0;
    alu_valid = 0; lsu_valid = 0; md_valid = 0; issue_valid = 0;
    alu_rd = 0; lsu_rd = 0; md_rd = 0; issue_rd = 0;
    alu_data = 0; lsu_data = 0; md_data = 0;

    // Readies stay low while in reset even with valid requests.
    @(negedge clk);
    lsu_valid = 1; md_valid = 1; lsu_rd = 4; md_rd = 6;
    #1;
    chk("rst_lsu_ready", lsu_ready, 1'b0);
    chk("rst_md_ready", md_ready, 1'b0);
    chk("rst_reg_write", reg_write, 1'b0);
    chk("rst_data", data, 32'h0);
    @(negedge clk);
    rst = 0; lsu_valid = 0; md_valid = 0;

    // ALU only.
    @(negedge clk);
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    @(negedge clk);
    alu_valid = 0;
    chk("alu_rw", reg_write, 1'b1);
    chk("alu_addr", write_addr, 5'd5);
    chk("alu_data", data, 32'hDEADBEEF);

    // Three-way contention: x1 (ALU), then x2 (LSU), then x3 (MD).
    @(negedge clk);
    alu_valid = 1; alu_rd = 1; alu_data = 32'hA1;
    lsu_valid = 1; lsu_rd = 2; lsu_data = 32'hB2;
    md_valid  = 1; md_rd  = 3; md_data  = 32'hC3;
    #1;
    chk("cont_lsu_ready_c1", lsu_ready, 1'b0);
    chk("cont_md_ready_c1", md_ready, 1'b0);
    @(negedge clk);
    chk("cont_w1", write_addr, 5'd1);
    alu_valid = 0;
    #1;
    chk("cont_lsu_ready_c2", lsu_ready, 1'b1);
    @(negedge clk);
    chk("cont_w2", write_addr, 5'd2);
    chk("cont_d2", data, 32'hB2);
    lsu_valid = 0;
    @(negedge clk);
    chk("cont_w3", write_addr, 5'd3);
    chk("cont_d3", data, 32'hC3);
    md_valid = 0;

    // Sustained LSU/MD contention alternates every cycle.
    @(negedge clk);
    lsu_valid = 1; lsu_rd = 16; lsu_data = 32'h16;
    md_valid  = 1; md_rd  = 17; md_data  = 32'h17;
    #1;
    chk("alt_lsu_first", lsu_ready, 1'b1);
    @(negedge clk);
    chk("alt_w16", write_addr, 5'd16);
    lsu_rd = 18; lsu_data = 32'h18;
    #1;
    chk("alt_md_ready", md_ready, 1'b1);
    chk("alt_lsu_wait", lsu_ready, 1'b0);
    @(negedge clk);
    chk("alt_w17", write_addr, 5'd17);
    md_rd = 19; md_data = 32'h19;
    @(negedge clk);
    chk("alt_w18", write_addr, 5'd18);
    lsu_valid = 0;
    @(negedge clk);
    chk("alt_w19", write_addr, 5'd19);
    md_valid = 0;

    // Stall hold for four edges, then the held write is released once.
    @(negedge clk);
    lsu_valid = 1; lsu_rd = 10; lsu_data = 32'h1010;
    @(negedge clk);
    chk("stall_start_addr", write_addr, 5'd10);
    lsu_valid = 0; stall = 1;
    md_valid = 1; md_rd = 11; md_data = 32'h1111;
    #1;
    chk("stall_md_ready", md_ready, 1'b0);
    chk("stall_lsu_ready", lsu_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_hold_rw", reg_write, 1'b1);
      chk("stall_hold_addr", write_addr, 5'd10);
      chk("stall_hold_data", data, 32'h1010);
    end
    stall = 0;
    #1;
    chk("unstall_md_ready", md_ready, 1'b1);
    @(negedge clk);
    chk("unstall_next_addr", write_addr, 5'd11);
    md_valid = 0;
    @(negedge clk);
    chk("idle_rw", reg_write, 1'b0);
    chk("idle_addr_hold", write_addr, 5'd11);

    // x0 write: consumed, not forwarded.
    md_valid = 1; md_rd = 0; md_data = 32'hFF;
    #1;
    chk("x0_md_ready", md_ready, 1'b1);
    @(negedge clk);
    md_valid = 0;
    chk("x0_rw", reg_write, 1'b0);
    chk("x0_pending", pending, 32'h0);

    // Scoreboard: issue x7, writeback three cycles later.
    issue_valid = 1; issue_rd = 7;
    @(negedge clk);
    issue_valid = 0;
    chk("sb7_c1", pending[7], SB);
    @(negedge clk);
    chk("sb7_c2", pending[7], SB);
    @(negedge clk);
    chk("sb7_c3", pending[7], SB);
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h77;
    @(negedge clk);
    lsu_valid = 0;
    chk("sb7_cleared", pending[7], 1'b0);
    chk("sb7_wb_addr", write_addr, 5'd7);
    // Same-edge issue and writeback of x9: set wins.
    issue_valid = 1; issue_rd = 9;
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99;
    @(negedge clk);
    issue_valid = 0; lsu_valid = 0;
    chk("sb9_set_wins", pending[9], SB);

    // Async reset while a write is presented; rr was left pointing at MD.
    alu_valid = 1; alu_rd = 12; alu_data = 32'hC0FFEE;
    @(negedge clk);
    alu_valid = 0;
    #3;
    chk("prerst_rw", reg_write, 1'b1);
    rst = 1;
    #1;
    chk("arst_rw", reg_write, 1'b0);
    chk("arst_addr", write_addr, 5'd0);
    chk("arst_data", data, 32'h0);
    chk("arst_pending", pending, 32'h0);
    @(negedge clk);
    rst = 0;
    lsu_valid = 1; lsu_rd = 13; lsu_data = 32'h13;
    md_valid  = 1; md_rd  = 14; md_data  = 32'h14;
    #1;
    chk("postrst_lsu_ready", lsu_ready, 1'b1);
    chk("postrst_md_ready", md_ready, 1'b0);
    @(negedge clk);
    chk("postrst_w13", write_addr, 5'd13);
    lsu_valid = 0;
    @(negedge clk);
    chk("postrst_w14", write_addr, 5'd14);
    md_valid = 0;
    @(negedge clk);
    @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
